// File: rtl/sipo_ctrl_pkg.sv
// Shared types and constants for the sipoMem ping-pong write controller.
package sipo_ctrl_pkg;

   typedef enum logic [1:0] {
      EMPTY   = 2'd0,
      FILLING = 2'd1,
      FULL    = 2'd2
   } bank_state_t;

   localparam int unsigned NBANKS = 2;

endpackage

// File: rtl/sipo_bank_fsm.sv
// Per-bank occupancy tracker: EMPTY -> FILLING -> FULL -> EMPTY.
module sipo_bank_fsm
   import sipo_ctrl_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        wr_hit_i,   // a word is written into this bank this cycle
   input  logic        wr_last_i,  // that word is the final word of the vector
   input  logic        rel_i,      // consumer releases this bank
   input  logic        clr_i,      // abort while this bank is the fill target
   output bank_state_t state_o
);

   bank_state_t state_q, state_d;

   // State register, asynchronously cleared.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= EMPTY;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state: abort only discards a partial fill; a FULL bank is never written.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         EMPTY: begin
            if (wr_hit_i) state_d = wr_last_i ? FULL : FILLING;
         end
         FILLING: begin
            if (clr_i)         state_d = EMPTY;
            else if (wr_hit_i) state_d = wr_last_i ? FULL : FILLING;
         end
         FULL: begin
            if (rel_i) state_d = EMPTY;
         end
         default: state_d = EMPTY;
      endcase
   end

   // Output: the registered state itself.
   always_comb begin
      state_o = state_q;
   end

endmodule

// File: rtl/sipo_pingpong_ctrl.sv
// Write-side controller for two sipoMem banks used as a ping-pong vector buffer.
module sipo_pingpong_ctrl
   import sipo_ctrl_pkg::*;
#(
   parameter int unsigned IWIDTH  = 10,
   parameter int unsigned NINPUTS = 8
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [IWIDTH-1:0]          s_data_i,
   input  logic                       s_valid_i,
   output logic                       s_ready_o,
   input  logic                       abort_i,
   output logic [1:0]                 mem_we_o,
   output logic [$clog2(NINPUTS)-1:0] mem_addr_o,
   output logic [IWIDTH-1:0]          mem_din_o,
   output logic                       vec_valid_o,
   output logic                       vec_bank_o,
   input  logic                       vec_done_i,
   output logic [$clog2(NINPUTS)-1:0] fill_idx_o,
   output logic                       err_o
);

   localparam int unsigned AW = $clog2(NINPUTS);

   logic          wr_bank_q, wr_bank_d;
   logic          rd_bank_q, rd_bank_d;
   logic [AW-1:0] wr_idx_q, wr_idx_d;
   logic          err_q, err_d;

   bank_state_t   bstate [NBANKS];
   logic          wr_fire, wr_last, rel_fire;

   // Handshake and output decode; s_ready depends on registers and abort only.
   always_comb begin
      s_ready_o   = (bstate[wr_bank_q] != FULL) && !abort_i;
      wr_fire     = s_valid_i && s_ready_o;
      wr_last     = (wr_idx_q == AW'(NINPUTS - 1));
      vec_valid_o = (bstate[rd_bank_q] == FULL);
      rel_fire    = vec_done_i && vec_valid_o;
      mem_we_o    = '0;
      if (wr_fire) mem_we_o[wr_bank_q] = 1'b1;
      mem_addr_o  = wr_idx_q;
      mem_din_o   = s_data_i;
      vec_bank_o  = rd_bank_q;
      fill_idx_o  = wr_idx_q;
      err_o       = err_q;
   end

   // One occupancy FSM per bank.
   for (genvar b = 0; b < NBANKS; b++) begin : g_bank
      sipo_bank_fsm u_fsm (
         .clk       (clk),
         .rst       (rst),
         .wr_hit_i  (mem_we_o[b]),
         .wr_last_i (wr_last),
         .rel_i     (rel_fire && (rd_bank_q == 1'(b))),
         .clr_i     (abort_i && (wr_bank_q == 1'(b))),
         .state_o   (bstate[b])
      );
   end

   // Next-state for fill pointer, bank selectors and sticky error.
   always_comb begin
      wr_idx_d  = wr_idx_q;
      wr_bank_d = wr_bank_q;
      rd_bank_d = rd_bank_q;
      err_d     = err_q;
      if (abort_i) begin
         wr_idx_d = '0;
      end else if (wr_fire) begin
         if (wr_last) begin
            wr_idx_d  = '0;
            wr_bank_d = ~wr_bank_q;
         end else begin
            wr_idx_d = wr_idx_q + AW'(1);
         end
      end
      if (rel_fire) rd_bank_d = ~rd_bank_q;
      // Releasing a bank that holds no complete vector is a consumer protocol error.
      if (vec_done_i && !vec_valid_o) err_d = 1'b1;
   end

   // Control registers, asynchronously cleared.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_idx_q  <= '0;
         wr_bank_q <= 1'b0;
         rd_bank_q <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         wr_idx_q  <= wr_idx_d;
         wr_bank_q <= wr_bank_d;
         rd_bank_q <= rd_bank_d;
         err_q     <= err_d;
      end
   end

endmodule

// File: tb/tb_sipo_pingpong_ctrl.sv
// Scoreboard bench for sipo_pingpong_ctrl: expected writes are queued by the
// stimulus and checked by an independent monitor on every mem_we pulse.
module tb_sipo_pingpong_ctrl;

   localparam int IW = 10;
   localparam int NI = 8;
   localparam int AW = 3;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [IW-1:0] s_data = '0;
   logic          s_valid = 1'b0;
   logic          s_ready;
   logic          abort = 1'b0;
   logic [1:0]    mem_we;
   logic [AW-1:0] mem_addr;
   logic [IW-1:0] mem_din;
   logic          vec_valid;
   logic          vec_bank;
   logic          vec_done = 1'b0;
   logic [AW-1:0] fill_idx;
   logic          err;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic          bank;
      logic [AW-1:0] addr;
      logic [IW-1:0] data;
   } wr_t;

   wr_t           exp_q[$];
   logic [IW-1:0] mem0 [NI];
   logic [IW-1:0] mem1 [NI];

   sipo_pingpong_ctrl #(.IWIDTH(IW), .NINPUTS(NI)) dut (
      .clk         (clk),
      .rst         (rst),
      .s_data_i    (s_data),
      .s_valid_i   (s_valid),
      .s_ready_o   (s_ready),
      .abort_i     (abort),
      .mem_we_o    (mem_we),
      .mem_addr_o  (mem_addr),
      .mem_din_o   (mem_din),
      .vec_valid_o (vec_valid),
      .vec_bank_o  (vec_bank),
      .vec_done_i  (vec_done),
      .fill_idx_o  (fill_idx),
      .err_o       (err)
   );

   always #5 clk = ~clk;

   // Bench model of the two sipoMem banks.
   always @(posedge clk) begin
      if (!rst) begin
         if (mem_we[0]) mem0[mem_addr] <= mem_din;
         if (mem_we[1]) mem1[mem_addr] <= mem_din;
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: every write the DUT issues must match the oldest queued expectation.
   always @(negedge clk) begin
      if (!rst && mem_we != 2'b00) begin
         if (exp_q.size() == 0) begin
            check("unexpected_write", {20'd0, mem_we, mem_addr, 7'd0}, 32'd0);
         end else begin
            wr_t e;
            e = exp_q.pop_front();
            check("wr_we", {30'd0, mem_we}, e.bank ? 32'd2 : 32'd1);
            check("wr_addr", {29'd0, mem_addr}, {29'd0, e.addr});
            check("wr_data", {22'd0, mem_din}, {22'd0, e.data});
         end
      end
   end

   task automatic push(input logic bank, input int addr, input int data);
      wr_t e;
      e.bank = bank;
      e.addr = AW'(addr);
      e.data = IW'(data);
      exp_q.push_back(e);
   endtask

   // Present one word and hold it until accepted; returns 1 ns after the write edge.
   task automatic put(input int data, input logic bank, input int addr);
      bit ok = 0;
      push(bank, addr, data);
      s_data  = IW'(data);
      s_valid = 1'b1;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (s_ready) begin
            ok = 1;
            break;
         end
      end
      if (!ok) check("put_timeout", 32'd0, 32'd1);
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_done();
      vec_done = 1'b1;
      @(posedge clk);
      #1;
      vec_done = 1'b0;
   endtask

   initial begin
      // Reset state.
      #12;
      @(negedge clk);
      check("rst_s_ready", {31'd0, s_ready}, 32'd1);
      check("rst_vec_valid", {31'd0, vec_valid}, 32'd0);
      rst = 1'b0;
      @(posedge clk);
      #1;
      @(negedge clk);
      check("rst_mem_we", {30'd0, mem_we}, 32'd0);
      check("rst_vec_bank", {31'd0, vec_bank}, 32'd0);
      check("rst_fill_idx", {29'd0, fill_idx}, 32'd0);
      check("rst_err", {31'd0, err}, 32'd0);
      @(posedge clk);
      #1;

      // Fill bank 0 with 0x001..0x008.
      for (int i = 0; i < NI; i++) put(i + 1, 1'b0, i);
      s_valid = 1'b0;
      @(negedge clk);
      check("fill_vec_valid", {31'd0, vec_valid}, 32'd1);
      check("fill_vec_bank", {31'd0, vec_bank}, 32'd0);
      check("fill_idx_wrap", {29'd0, fill_idx}, 32'd0);
      for (int i = 0; i < NI; i++) check("mem0_fill", {22'd0, mem0[i]}, i + 1);

      // Ping-pong: words 9..16 into bank 1, then stall with both banks full.
      @(posedge clk);
      #1;
      for (int i = 0; i < NI; i++) put(i + 9, 1'b1, i);
      s_valid = 1'b0;
      @(negedge clk);
      check("both_full_s_ready", {31'd0, s_ready}, 32'd0);
      @(posedge clk);
      #1;
      push(1'b0, 0, 17);
      s_data  = IW'(17);
      s_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("stall_s_ready", {31'd0, s_ready}, 32'd0);
         check("stall_mem_we", {30'd0, mem_we}, 32'd0);
      end
      @(posedge clk);
      #1;
      pulse_done();
      @(negedge clk);
      check("pp_vec_bank", {31'd0, vec_bank}, 32'd1);
      check("pp_vec_valid", {31'd0, vec_valid}, 32'd1);
      check("pp_s_ready", {31'd0, s_ready}, 32'd1);
      check("pp_w17_we", {30'd0, mem_we}, 32'd1);
      @(posedge clk);
      #1;
      s_valid = 1'b0;
      for (int i = 0; i < NI; i++) check("mem1_fill", {22'd0, mem1[i]}, i + 9);

      // Simultaneous: finish bank 0, free bank 1, bring bank 1 to index 7.
      for (int i = 1; i < NI; i++) put(i + 17, 1'b0, i);
      s_valid = 1'b0;
      pulse_done();
      for (int i = 0; i < NI - 1; i++) put(i + 32, 1'b1, i);
      s_valid = 1'b0;
      @(negedge clk);
      check("sim_fill_idx7", {29'd0, fill_idx}, 32'd7);
      @(posedge clk);
      #1;
      push(1'b1, 7, 39);
      s_data   = IW'(39);
      s_valid  = 1'b1;
      vec_done = 1'b1;
      @(negedge clk);
      check("sim_mem_we", {30'd0, mem_we}, 32'd2);
      @(posedge clk);
      #1;
      s_valid  = 1'b0;
      vec_done = 1'b0;
      @(negedge clk);
      check("sim_vec_valid", {31'd0, vec_valid}, 32'd1);
      check("sim_vec_bank", {31'd0, vec_bank}, 32'd1);
      check("sim_s_ready", {31'd0, s_ready}, 32'd1);
      check("sim_fill_idx", {29'd0, fill_idx}, 32'd0);
      @(posedge clk);
      #1;

      // Abort a 3-word partial fill of bank 0; bank 1 stays full.
      for (int i = 0; i < 3; i++) put(i + 'h100, 1'b0, i);
      s_valid = 1'b0;
      @(negedge clk);
      check("abort_pre_idx", {29'd0, fill_idx}, 32'd3);
      @(posedge clk);
      #1;
      abort   = 1'b1;
      s_valid = 1'b1;
      s_data  = IW'('h3FF);
      @(negedge clk);
      check("abort_mem_we", {30'd0, mem_we}, 32'd0);
      check("abort_s_ready", {31'd0, s_ready}, 32'd0);
      @(posedge clk);
      #1;
      abort   = 1'b0;
      s_valid = 1'b0;
      @(negedge clk);
      check("abort_fill_idx", {29'd0, fill_idx}, 32'd0);
      check("abort_vec_valid", {31'd0, vec_valid}, 32'd1);
      check("abort_vec_bank", {31'd0, vec_bank}, 32'd1);
      @(posedge clk);
      #1;
      for (int i = 0; i < NI; i++) put(i + 'h200, 1'b0, i);
      s_valid = 1'b0;
      @(negedge clk);
      for (int i = 0; i < NI; i++) check("mem0_refill", {22'd0, mem0[i]}, i + 'h200);
      check("refill_vec_bank", {31'd0, vec_bank}, 32'd1);

      // Protocol error: drain both banks, then release with nothing valid.
      @(posedge clk);
      #1;
      pulse_done();
      pulse_done();
      @(negedge clk);
      check("err_pre_valid", {31'd0, vec_valid}, 32'd0);
      check("err_pre", {31'd0, err}, 32'd0);
      @(posedge clk);
      #1;
      pulse_done();
      @(negedge clk);
      check("err_set", {31'd0, err}, 32'd1);
      check("err_vec_bank", {31'd0, vec_bank}, 32'd1);
      check("err_vec_valid", {31'd0, vec_valid}, 32'd0);
      @(posedge clk);
      #1;
      put('h41, 1'b1, 0);
      put('h42, 1'b1, 1);
      s_valid = 1'b0;
      @(negedge clk);
      check("err_sticky", {31'd0, err}, 32'd1);
      check("err_fill_idx", {29'd0, fill_idx}, 32'd2);

      // Async reset with bank 1 full and bank 0 mid-fill.
      @(posedge clk);
      #1;
      for (int i = 2; i < NI; i++) put(i + 'h40, 1'b1, i);
      for (int i = 0; i < 3; i++) put(i + 'h50, 1'b0, i);
      s_valid = 1'b0;
      #2;
      rst = 1'b1;
      #1;
      check("arst_fill_idx", {29'd0, fill_idx}, 32'd0);
      check("arst_vec_valid", {31'd0, vec_valid}, 32'd0);
      check("arst_vec_bank", {31'd0, vec_bank}, 32'd0);
      check("arst_s_ready", {31'd0, s_ready}, 32'd1);
      check("arst_err", {31'd0, err}, 32'd0);
      #1;
      rst = 1'b0;
      @(posedge clk);
      #1;
      put('h55, 1'b0, 0);
      s_valid = 1'b0;
      @(negedge clk);
      check("post_rst_idx", {29'd0, fill_idx}, 32'd1);
      check("mem0_post_rst", {22'd0, mem0[0]}, 32'h55);
      check("queue_drained", exp_q.size(), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
